fp_seg_display: RTL and testbench

//  Downstream consumer of the 12-bit-to-float converter. Captures {S,E,F} under a

---
 rtl/fp_seg_display.sv | 144 ++++++++++++++
 tb/tb_fp_seg_display.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_seg_display.sv
// Latches a {sign, exponent, significand} sample and scans it onto a 4-digit
// common-anode 7-segment display: sign, blank, exponent with point, significand.
module fp_seg_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_S,
    input  logic [2:0] in_E,
    input  logic [3:0] in_F,
    input  logic       hold,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       shown,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } digit_e;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_e           state_q, state_d;
    logic             s_q, s_d;
    logic [2:0]       e_q, e_d;
    logic [3:0]       f_q, f_d;
    logic             shown_q, shown_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'b1000000;
            4'h1: r = 7'b1111001;
            4'h2: r = 7'b0100100;
            4'h3: r = 7'b0110000;
            4'h4: r = 7'b0011001;
            4'h5: r = 7'b0010010;
            4'h6: r = 7'b0000010;
            4'h7: r = 7'b1111000;
            4'h8: r = 7'b0000000;
            4'h9: r = 7'b0010000;
            4'hA: r = 7'b0001000;
            4'hB: r = 7'b0000011;
            4'hC: r = 7'b1000110;
            4'hD: r = 7'b0100001;
            4'hE: r = 7'b0000110;
            default: r = 7'b0001110;
        endcase
        return r;
    endfunction

    // Handshake: a sample transfers on any rising edge where in_valid && in_ready;
    // in_ready is simply ~hold, and a sample offered while held is discarded.
    assign in_ready  = ~hold;
    assign tick      = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign shown     = shown_q;
    assign dbg_state = state_q;

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        state_d = state_q;
        s_d     = s_q;
        e_d     = e_q;
        f_d     = f_q;
        shown_d = shown_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;

        if (in_valid && in_ready) begin
            s_d     = in_S;
            e_d     = in_E;
            f_d     = in_F;
            shown_d = 1'b1;
        end

        // Digit content uses the pre-edge capture, so a same-edge sample waits a visit.
        if (tick) begin
            case (state_q)
                D3:      state_d = D0;
                D0:      state_d = D1;
                D1:      state_d = D2;
                default: state_d = D3;
            endcase
            an_d = ~(4'b0001 << state_d);
            dp_d = 1'b1;
            if (!shown_q) begin
                seg_d = SEG_DASH;
            end else begin
                case (state_d)
                    D3:      seg_d = s_q ? SEG_DASH : SEG_BLANK;
                    D2:      seg_d = SEG_BLANK;
                    D1: begin
                        seg_d = hex7({1'b0, e_q});
                        dp_d  = 1'b0;
                    end
                    default: seg_d = hex7(f_q);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= D3;
            s_q     <= 1'b0;
            e_q     <= 3'd0;
            f_q     <= 4'd0;
            shown_q <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            s_q     <= s_d;
            e_q     <= e_d;
            f_q     <= f_d;
            shown_q <= shown_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

endmodule

// File: tb/tb_fp_seg_display.sv
// Directed bench for fp_seg_display with a 4-cycle refresh period.
module tb_fp_seg_display;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_S;
    logic [2:0] in_E;
    logic [3:0] in_F;
    logic       hold;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       shown;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    fp_seg_display #(
        .REFRESH_DIV(4),
        .CNT_W      (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_S     (in_S),
        .in_E     (in_E),
        .in_F     (in_F),
        .hold     (hold),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .shown    (shown),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the edge on which digit d becomes lit (a fresh entry).
    task automatic wait_digit(input int d);
        logic [3:0] tgt;
        logic [3:0] prev;
        bit         found;
        tgt   = ~(4'b0001 << d);
        prev  = an;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            step();
            if (an === tgt && prev !== tgt) found = 1'b1;
            prev = an;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_digit%0d: an=%b never became %b", d, an, tgt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; in_S = 1'b0; in_E = 3'd0; in_F = 4'd0; hold = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || shown !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: an=%b seg=%b dp=%b shown=%b want 1111 1111111 1 0", an, seg, dp, shown);
        end
        checks++;
        if (dbg_state !== 2'd3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: dbg_state=%0d in_ready=%b want 3 1", dbg_state, in_ready);
        end
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_scan_blank();
        logic [3:0] exp_an;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (an !== 4'b1111) begin
                errors++;
                $display("FAIL pre_tick%0d: an=%b want 1111", i, an);
            end
        end
        for (int i = 0; i < 16; i++) begin
            step();
            case (i / 4)
                0:       exp_an = 4'b1110;
                1:       exp_an = 4'b1101;
                2:       exp_an = 4'b1011;
                default: exp_an = 4'b0111;
            endcase
            checks++;
            if (an !== exp_an || seg !== 7'b0111111 || dp !== 1'b1 || shown !== 1'b0) begin
                errors++;
                $display("FAIL scan_blank%0d: an=%b seg=%b dp=%b shown=%b want %b 0111111 1 0",
                         i, an, seg, dp, shown, exp_an);
            end
        end
    endtask

    task automatic test_capture();
        wait_digit(3);
        in_valid = 1'b1; in_S = 1'b1; in_E = 3'd5; in_F = 4'd11;
        step();
        in_valid = 1'b0;
        checks++;
        if (shown !== 1'b1) begin
            errors++;
            $display("FAIL capture_shown: shown=%b want 1", shown);
        end
        wait_digit(0);
        checks++;
        if (seg !== 7'b0000011 || dp !== 1'b1) begin
            errors++;
            $display("FAIL capture_d0: seg=%b dp=%b want 0000011 1", seg, dp);
        end
        wait_digit(1);
        checks++;
        if (seg !== 7'b0010010 || dp !== 1'b0) begin
            errors++;
            $display("FAIL capture_d1: seg=%b dp=%b want 0010010 0", seg, dp);
        end
        wait_digit(2);
        checks++;
        if (seg !== 7'b1111111 || dp !== 1'b1) begin
            errors++;
            $display("FAIL capture_d2: seg=%b dp=%b want 1111111 1", seg, dp);
        end
        wait_digit(3);
        checks++;
        if (seg !== 7'b0111111 || dp !== 1'b1) begin
            errors++;
            $display("FAIL capture_d3: seg=%b dp=%b want 0111111 1", seg, dp);
        end
    endtask

    task automatic test_hold();
        hold = 1'b1; in_valid = 1'b1; in_S = 1'b0; in_E = 3'd0; in_F = 4'd0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_ready: in_ready=%b want 0", in_ready);
        end
        wait_digit(0);
        checks++;
        if (seg !== 7'b0000011 || dp !== 1'b1) begin
            errors++;
            $display("FAIL hold_d0: seg=%b dp=%b want 0000011 1", seg, dp);
        end
        wait_digit(1);
        checks++;
        if (seg !== 7'b0010010 || dp !== 1'b0) begin
            errors++;
            $display("FAIL hold_d1: seg=%b dp=%b want 0010010 0", seg, dp);
        end
        wait_digit(3);
        checks++;
        if (seg !== 7'b0111111 || dp !== 1'b1) begin
            errors++;
            $display("FAIL hold_d3: seg=%b dp=%b want 0111111 1", seg, dp);
        end
        hold = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_tick_capture();
        wait_digit(3);
        step();
        step();
        step();
        in_valid = 1'b1; in_S = 1'b0; in_E = 3'd7; in_F = 4'd15;
        step();
        in_valid = 1'b0;
        checks++;
        if (an !== 4'b1110 || seg !== 7'b0000011 || dp !== 1'b1) begin
            errors++;
            $display("FAIL tick_cap_old_d0: an=%b seg=%b dp=%b want 1110 0000011 1", an, seg, dp);
        end
        wait_digit(1);
        checks++;
        if (seg !== 7'b1111000 || dp !== 1'b0) begin
            errors++;
            $display("FAIL tick_cap_d1: seg=%b dp=%b want 1111000 0", seg, dp);
        end
        wait_digit(2);
        checks++;
        if (seg !== 7'b1111111 || dp !== 1'b1) begin
            errors++;
            $display("FAIL tick_cap_d2: seg=%b dp=%b want 1111111 1", seg, dp);
        end
        wait_digit(3);
        checks++;
        if (seg !== 7'b1111111 || dp !== 1'b1) begin
            errors++;
            $display("FAIL tick_cap_d3_pos: seg=%b dp=%b want 1111111 1", seg, dp);
        end
        wait_digit(0);
        checks++;
        if (seg !== 7'b0001110 || dp !== 1'b1) begin
            errors++;
            $display("FAIL tick_cap_new_d0: seg=%b dp=%b want 0001110 1", seg, dp);
        end
    endtask

    task automatic test_reset_mid_scan();
        wait_digit(2);
        step();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || shown !== 1'b0) begin
            errors++;
            $display("FAIL midreset_dark: an=%b seg=%b dp=%b shown=%b want 1111 1111111 1 0", an, seg, dp, shown);
        end
        step();
        checks++;
        if (an !== 4'b1111 || dbg_state !== 2'd3) begin
            errors++;
            $display("FAIL midreset_held: an=%b dbg_state=%0d want 1111 3", an, dbg_state);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (an !== 4'b1111) begin
                errors++;
                $display("FAIL midreset_pre%0d: an=%b want 1111", i, an);
            end
        end
        step();
        checks++;
        if (an !== 4'b1110 || seg !== 7'b0111111 || dp !== 1'b1 || shown !== 1'b0) begin
            errors++;
            $display("FAIL midreset_first_d0: an=%b seg=%b dp=%b shown=%b want 1110 0111111 1 0",
                     an, seg, dp, shown);
        end
    endtask

    initial begin
        test_reset();
        test_scan_blank();
        test_capture();
        test_hold();
        test_tick_capture();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
